// File: rtl/cla_addsub_if.sv
// Valid/ready operand and result bundle for cla_addsub_pipe.
// slave = the adder, master = the producer/consumer side.
interface cla_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one slice per stage,
// with a single global advance (valid/ready) and flag outputs.
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  cla_addsub_if.slave bus
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;

  typedef struct packed {
    logic             v;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } st_t;

  logic adv;
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;
  st_t  fin_d;
  st_t  fin_q;

  // Groups of 4 are full lookahead; group carries ripple only
  // inside one slice.
  function automatic logic [SW:0] slice_add(
    input logic [SW-1:0] x,
    input logic [SW-1:0] y,
    input logic          ci
  );
    logic [SW-1:0] r;
    logic          c;
    logic [3:0]    p;
    logic [3:0]    g;
    logic [4:0]    cc;
    r = '0;
    c = ci;
    for (int j = 0; j < NG; j++) begin
      p = x[j*4 +: 4] ^ y[j*4 +: 4];
      g = x[j*4 +: 4] & y[j*4 +: 4];
      cc[0] = c;
      cc[1] = g[0] | (p[0] & c);
      cc[2] = g[1] | (p[1] & g[0])
            | (p[1] & p[0] & c);
      cc[3] = g[2] | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c);
      cc[4] = g[3] | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (&p & c);
      r[j*4 +: 4] = p ^ cc[3:0];
      c = cc[4];
    end
    return {c, r};
  endfunction

  assign adv          = !fin_q.v || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    st_t         src;
    st_t         st_d;
    st_t         st_q;
    logic [SW:0] r;

    if (k == 0) begin : g_in
      always_comb begin
        src   = '0;
        src.v = bus.in_valid;
        src.c = bus.cin;
        src.a = bus.a;
        src.b = bus.op ? ~bus.b : bus.b;
      end
    end else begin : g_mid
      assign src = g_stage[k-1].st_q;
    end

    always_comb begin
      r    = slice_add(src.a[k*SW +: SW],
                       src.b[k*SW +: SW],
                       src.c);
      st_d = src;
      st_d.c = r[SW];
      st_d.s[k*SW +: SW] = r[SW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q <= '0;
      end else if (adv) begin
        st_q <= st_d;
      end
    end
  end

  assign fin_d = g_stage[STAGES-1].st_d;
  assign fin_q = g_stage[STAGES-1].st_q;

  always_comb begin
    ovf_d  = (fin_d.a[WIDTH-1] == fin_d.b[WIDTH-1])
          && (fin_d.s[WIDTH-1] != fin_d.a[WIDTH-1]);
    zero_d = (fin_d.s == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.out_valid = fin_q.v;
  assign bus.s         = fin_q.s;
  assign bus.cout      = fin_q.c;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed-vector and scoreboard bench for cla_addsub_pipe
// at WIDTH=16, STAGES=2.
module tb_cla_addsub_pipe;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   n_out = 0;
  logic [W+2:0] exp_q[$];

  cla_addsub_if #(.WIDTH(W)) bus ();

  cla_addsub_pipe #(
    .WIDTH (W),
    .STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Golden model: plain wide add, returns {s, cout, ovf, zero}.
  function automatic logic [W+2:0] model(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic cin, input logic op);
    logic [W-1:0] be;
    logic [W:0]   sum;
    logic         ov;
    be  = op ? ~b : b;
    sum = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, cin};
    ov  = (a[W-1] == be[W-1]) && (sum[W-1] != a[W-1]);
    return {sum[W-1:0], sum[W], ov, sum[W-1:0] == '0};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("in_ready_adv", bus.in_ready,
          !bus.out_valid || bus.out_ready);
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          chk("sb_result",
              {bus.s, bus.cout, bus.ovf, bus.zero},
              exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.op));
    end
  end

  task automatic drive(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic cin, input logic op);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.op = op;
    bus.in_valid = 1'b1;
  endtask

  // Called at posedge+1 with operands presented.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      bus.in_valid = 1'b0;
    end while (!bus.out_valid && lat < 10);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  vec_t tbl[12];
  int   lat;
  int   acc;
  int   n0;
  int   idx;
  logic [W-1:0] hold_s;
  logic         hold_c;

  initial begin
    tbl[0]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b0,
                16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{16'h0000, 16'hFFFF, 1'b1, 1'b0,
                16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0,
                16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1,
                16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0,
                16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0,
                16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{16'h8000, 16'h0001, 1'b1, 1'b1,
                16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{16'h1234, 16'h1234, 1'b1, 1'b1,
                16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0,
                16'h0100, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0,
                16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{16'h1234, 16'h4321, 1'b1, 1'b0,
                16'h5556, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{16'h0003, 16'h0005, 1'b1, 1'b1,
                16'hFFFE, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a   = '0;
    bus.b   = '0;
    bus.cin = 1'b0;
    bus.op  = 1'b0;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_s", bus.s, 0);
    chk("rst_flags", {bus.cout, bus.ovf, bus.zero}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Directed table, one transaction at a time.
    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].op);
      wait_out(lat);
      chk($sformatf("tbl%0d_lat", i), lat, 2);
      chk($sformatf("tbl%0d_s", i), bus.s, tbl[i].s);
      chk($sformatf("tbl%0d_flags", i),
          {bus.cout, bus.ovf, bus.zero},
          {tbl[i].co, tbl[i].ov, tbl[i].z});
    end
    drain();

    // Full-rate stream a=0..1023, b=FFFF, cin=1.
    n0  = n_out;
    acc = 0;
    for (int c = 0; c < 1024; c++) begin
      @(posedge clk);
      #1;
      drive(c[W-1:0], 16'hFFFF, 1'b1, 1'b0);
      #1;
      if (bus.in_ready) acc++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stream_accepts", acc, 1024);
    chk("stream_outputs", n_out - n0, 1024);
    drain();

    // Five-cycle consumer stall mid-stream.
    idx = 0;
    n0  = n_out;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      bus.out_ready = !(c >= 8 && c < 13);
      if (idx < 20)
        drive(16'h0100 + idx[W-1:0], 16'h0011,
              idx[0], idx[1]);
      else
        bus.in_valid = 1'b0;
      #1;
      if (c == 8) begin
        hold_s = bus.s;
        hold_c = bus.cout;
      end
      if (c > 8 && c < 13) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_s", bus.s, hold_s);
        chk("stall_cout", bus.cout, hold_c);
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    chk("stall_outputs", n_out - n0, 20);
    drain();

    // Reset with two items in flight.
    @(posedge clk);
    #1;
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(16'h3333, 16'h4444, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = n_out;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("postrst_idle", bus.out_valid, 0);
    end
    chk("postrst_no_out", n_out - n0, 0);
    drive(16'h00F0, 16'h0F0F, 1'b0, 1'b0);
    wait_out(lat);
    chk("postrst_lat", lat, 2);
    chk("postrst_s", bus.s, 16'h0FFF);
    drain();

    // Random traffic with random back-pressure.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.cin       = 1'($urandom_range(0, 1));
      bus.op        = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/cla_addsub_pipe.md
CLA_ADDSUB_PIPE -- requirements
Module: cla_addsub_pipe

Interface
- REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a multiple of 4 and of 4*STAGES.
- REQ-002 Parameter STAGES, default 2, pipeline depth in cycles; legal range 1..4.
- REQ-003 Port clk  input  1  rising-edge clock for all state.
- REQ-004 Port rst  input  1  asynchronous, active-high reset.
- REQ-005 Port in_valid  input  1  operand set present on a, b, cin, op.
- REQ-006 Port in_ready  output  1  block accepts operands this cycle.
- REQ-007 Port a, b  input  WIDTH each  operands.
- REQ-008 Port cin  input  1  carry-in.
- REQ-009 Port op  input  1  0 = add, 1 = subtract.
- REQ-010 Port out_valid  output  1  result on s/cout/ovf/zero is valid.
- REQ-011 Port out_ready  input  1  consumer takes the result this cycle.
- REQ-012 Port s  output  WIDTH  sum/difference.
- REQ-013 Port cout  output  1  carry-out of MSB.
- REQ-014 Port ovf  output  1  two's-complement signed overflow.
- REQ-015 Port zero  output  1  s equals 0.

Function
- REQ-016 op=0: {cout,s} SHALL equal a + b + cin; op=1: {cout,s} SHALL equal a + ~b + cin (cin=1 gives a-b; cout=1 means no borrow).
- REQ-017 ovf SHALL be 1 iff the effective operands (a, b or ~b) have equal MSBs and the MSB of s differs from them.
- REQ-018 zero SHALL be 1 iff s == 0, computed from the final s in the same output register.
- REQ-019 The adder SHALL be split into STAGES slices of WIDTH/STAGES bits; each slice is a 4-bit-group carry-lookahead adder; stage k resolves slice k and registers its partial sum, group carry, and the remaining unresolved operand bits.
- REQ-020 No ripple path SHALL span more than one slice between registers.
- REQ-021 Transfer occurs on a rising edge when in_valid && in_ready (input) or out_valid && out_ready (output).
- REQ-022 Latency SHALL be exactly STAGES cycles from input transfer to out_valid=1 with no stall.
- REQ-023 Global advance = !out_valid || out_ready; all stages and their valid bits SHALL move only when advance=1; in_ready SHALL equal advance (combinational).
- REQ-024 With advance=0, s/cout/ovf/zero/out_valid SHALL hold stable; bubbles are not collapsed.
- REQ-025 Throughput SHALL be one result per cycle while in_valid=1 and out_ready=1.
- REQ-026 Results SHALL emerge in acceptance order; no transfer lost or duplicated.
- REQ-027 When in_valid=0 and advance=1, a bubble (valid=0) SHALL enter stage 1.
- REQ-028 Output transfer and input transfer in the same cycle SHALL both complete.
- REQ-029 Wrap-around: a=all-ones, b=0, cin=1, op=0 SHALL give s=0, cout=1, zero=1.

Reset
- REQ-030 Asserting rst SHALL immediately clear all stage valid bits, out_valid, s, cout, ovf, zero to 0, independent of clk.
- REQ-031 Reset mid-operation SHALL discard all in-flight operand sets; none appear after release.
- REQ-032 in_ready SHALL be 1 during and after reset (pipeline empty, out_valid=0).
- REQ-033 First input transfer after release SHALL be on the first rising edge with rst=0 and in_valid=1.

Verification (WIDTH=16, STAGES=2)
- REQ-034 a=0000, b=FFFF, cin=0, op=0 -> 2 cycles later s=FFFF, cout=0, ovf=0, zero=0; cin=1 -> s=0000, cout=1, zero=1.
- REQ-035 a=7FFF, b=0001, cin=0, op=0 -> s=8000, ovf=1, cout=0; a=0005, b=0007, cin=1, op=1 -> s=FFFE, cout=0, ovf=0.
- REQ-036 Stream a=0..1023, b=FFFF, cin=1, op=0 with out_ready=1 -> one result per cycle, each s=a, cout=1, in order.
- REQ-037 out_ready=0 for 5 cycles mid-stream -> in_ready=0 while out_valid=1, outputs stable, no loss/duplication after release.
- REQ-038 rst pulsed with 2 items in flight -> out_valid=0 immediately; nothing emitted until new inputs; next result after 2 cycles.
- REQ-039 Randomised a, b, cin, op, in_valid, out_ready for 10k cycles, also WIDTH=32 STAGES=4 -> every result matches golden add/sub model and flags.
